hist_chan_mux: RTL and testbench

HIST_CHAN_MUX -- requirements
Module: hist_chan_mux

---
 rtl/hist_chan_mux.sv | 112 +++++++++++
 tb/tb_hist_chan_mux.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hist_chan_mux.sv
// hist_chan_mux: selects one of NUM_CH component channels (fixed or auto-scanned
// frame by frame), registers it with one cycle of latency and counts the valid
// beats of each selected frame.
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   i_start_frame          frame-start pulse; the only point where the channel may change
//   i_mode                 0 = fixed channel from i_ch_sel, 1 = auto-scan
//   i_ch_sel               requested channel in fixed mode
//   i_in_valid/_data/_frame_end  per-channel strobe, component, last-pixel pulse
//   o_out_data/_valid/_frame_end selected channel, registered
//   o_out_ch               channel that drove the outputs this cycle
//   o_pix_count(_valid)    valid-beat count of the last completed frame, update pulse
//   o_sel_err              sticky out-of-range channel request flag
module hist_chan_mux #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 24,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_start_frame,
   input  logic                     i_mode,
   input  logic [SEL_W-1:0]         i_ch_sel,
   input  logic [NUM_CH-1:0]        i_in_valid,
   input  logic [NUM_CH*DATA_W-1:0] i_in_data,
   input  logic [NUM_CH-1:0]        i_in_frame_end,
   output logic [DATA_W-1:0]        o_out_data,
   output logic                     o_out_valid,
   output logic                     o_out_frame_end,
   output logic [SEL_W-1:0]         o_out_ch,
   output logic [CNT_W-1:0]         o_pix_count,
   output logic                     o_pix_count_valid,
   output logic                     o_sel_err
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t r_state, w_next_state;
   logic [SEL_W-1:0]  r_act_ch, r_out_ch, w_next_act, w_auto_act, w_fix_act;
   logic [DATA_W-1:0] r_out_data, w_sel_data;
   logic [CNT_W-1:0]  r_cnt, r_pix_count, w_cnt_inc, w_next_cnt;
   logic r_first, r_sel_err, r_out_valid, r_out_fe, r_pix_valid;
   logic w_run, w_sel_valid, w_sel_fe, w_in_range, w_next_err, w_next_first;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;

   always_comb begin
      w_next_state = r_state;
      if (i_start_frame) w_next_state = RUN;
      w_run = r_state == RUN;
   end

   // selection uses the current act_ch, so a start_frame cycle still drives the old channel
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_fe    = 1'b0;
      w_sel_data  = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (r_act_ch == SEL_W'(k)) begin
            w_sel_valid = i_in_valid[k] & w_run;
            w_sel_fe    = i_in_frame_end[k] & w_run;
            w_sel_data  = i_in_data[k*DATA_W +: DATA_W];
         end
   end

   always_comb begin
      w_in_range   = int'(i_ch_sel) < NUM_CH;
      w_fix_act    = w_in_range ? i_ch_sel : '0;
      // r_first restarts the scan at channel 0 after IDLE or after any cycle in fixed mode
      w_auto_act   = (r_first || r_act_ch == SEL_W'(NUM_CH-1)) ? '0 : r_act_ch + SEL_W'(1);
      w_next_act   = i_start_frame ? (i_mode ? w_auto_act : w_fix_act) : r_act_ch;
      w_next_err   = i_start_frame ? (~i_mode & ~w_in_range) : r_sel_err;
      w_next_first = ~i_mode | (r_first & ~i_start_frame);
      w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
      w_next_cnt   = (i_start_frame | w_sel_fe) ? '0 : (w_sel_valid ? w_cnt_inc : r_cnt);
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_act_ch    <= '0;
         r_first     <= 1'b1;
         r_sel_err   <= 1'b0;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_fe    <= 1'b0;
         r_out_ch    <= '0;
         r_pix_count <= '0;
         r_pix_valid <= 1'b0;
      end else begin
         r_act_ch    <= w_next_act;
         r_first     <= w_next_first;
         r_sel_err   <= w_next_err;
         r_cnt       <= w_next_cnt;
         r_out_valid <= w_sel_valid;
         r_out_fe    <= w_sel_fe;
         r_out_ch    <= r_act_ch;
         r_pix_valid <= w_sel_fe;
         if (w_sel_valid) r_out_data <= w_sel_data;
         // the closing beat itself is included in the captured count
         if (w_sel_fe) r_pix_count <= w_sel_valid ? w_cnt_inc : r_cnt;
      end

   assign o_out_data        = r_out_data;
   assign o_out_valid       = r_out_valid;
   assign o_out_frame_end   = r_out_fe;
   assign o_out_ch          = r_out_ch;
   assign o_pix_count       = r_pix_count;
   assign o_pix_count_valid = r_pix_valid;
   assign o_sel_err         = r_sel_err;
endmodule

// File: tb/tb_hist_chan_mux.sv
// tb_hist_chan_mux: scoreboard bench for hist_chan_mux (NUM_CH=4, CNT_W=4, SEL_W=3).
module tb_hist_chan_mux;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_start_frame = 1'b0;
   logic        i_mode = 1'b0;
   logic [2:0]  i_ch_sel = '0;
   logic [3:0]  i_in_valid = '0;
   logic [31:0] i_in_data = '0;
   logic [3:0]  i_in_frame_end = '0;
   logic [7:0]  o_out_data;
   logic        o_out_valid, o_out_frame_end, o_pix_count_valid, o_sel_err;
   logic [2:0]  o_out_ch;
   logic [3:0]  o_pix_count;

   typedef struct {int data; bit v; bit fe; int pc;} exp_t;
   exp_t q[$];
   int n_chk = 0, n_fail = 0;
   int m_act, m_cnt, m_data, m_out_ch;
   bit m_run, m_first, m_err;
   int seq[5] = '{0, 1, 2, 3, 0};

   hist_chan_mux #(.NUM_CH(4), .DATA_W(8), .CNT_W(4), .SEL_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .i_start_frame(i_start_frame), .i_mode(i_mode),
      .i_ch_sel(i_ch_sel), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
      .i_in_frame_end(i_in_frame_end), .o_out_data(o_out_data), .o_out_valid(o_out_valid),
      .o_out_frame_end(o_out_frame_end), .o_out_ch(o_out_ch), .o_pix_count(o_pix_count),
      .o_pix_count_valid(o_pix_count_valid), .o_sel_err(o_sel_err));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_act = 0; m_first = 1; m_err = 0;
      m_cnt = 0; m_data = 0; m_out_ch = 0;
      q.delete();
   endtask

   task automatic check_reset_vals();
      check("rst_data", 32'(o_out_data), 0);
      check("rst_valid", 32'(o_out_valid), 0);
      check("rst_fe", 32'(o_out_frame_end), 0);
      check("rst_ch", 32'(o_out_ch), 0);
      check("rst_pix", 32'(o_pix_count), 0);
      check("rst_pixv", 32'(o_pix_count_valid), 0);
      check("rst_err", 32'(o_sel_err), 0);
   endtask

   task automatic step(input bit sf, input bit md, input logic [2:0] sel,
                       input logic [3:0] v, input logic [3:0] fe);
      logic [31:0] d;
      int dsel, ninc;
      bit sv, sfe;
      exp_t it;
      d = $urandom;
      i_start_frame = sf; i_mode = md; i_ch_sel = sel;
      i_in_valid = v; i_in_data = d; i_in_frame_end = fe;
      sv   = m_run && v[m_act];
      sfe  = m_run && fe[m_act];
      dsel = int'(d[m_act*8 +: 8]);
      ninc = (m_cnt == 15) ? 15 : m_cnt + 1;
      if (sv || sfe) begin
         it.data = sv ? dsel : m_data;
         it.v = sv; it.fe = sfe;
         it.pc = sv ? ninc : m_cnt;
         q.push_back(it);
      end
      if (sv) m_data = dsel;
      m_out_ch = m_act;
      m_cnt = (sf || sfe) ? 0 : (sv ? ninc : m_cnt);
      if (sf) begin
         m_run = 1;
         if (!md) begin
            m_err = sel >= 4;
            m_act = (sel < 4) ? int'(sel) : 0;
         end else begin
            m_err = 0;
            m_act = m_first ? 0 : (m_act + 1) % 4;
         end
      end
      if (!md) m_first = 1; else if (sf) m_first = 0;
      @(posedge clk); #1;
      if (q.size() == 0)
         check("no_out", 32'({o_pix_count_valid, o_out_frame_end, o_out_valid}), 0);
      else begin
         it = q.pop_front();
         check("valid", 32'(o_out_valid), 32'(it.v));
         check("frame_end", 32'(o_out_frame_end), 32'(it.fe));
         check("pix_valid", 32'(o_pix_count_valid), 32'(it.fe));
         check("data", 32'(o_out_data), 32'(it.data));
         if (it.fe) check("pix_count", 32'(o_pix_count), 32'(it.pc));
      end
      check("out_ch", 32'(o_out_ch), 32'(m_out_ch));
      check("sel_err", 32'(o_sel_err), 32'(m_err));
   endtask

   // start_frame then nb beats on the active channel (others random); ch_sel switches to sel_mid halfway
   task automatic frame(input bit md, input logic [2:0] sel, input logic [2:0] sel_mid,
                        input int nb, input bit fe_last, input int exp_ch);
      logic [3:0] v, fe;
      step(1, md, sel, 4'b0, 4'b0);
      for (int b = 0; b < nb; b++) begin
         v  = 4'($urandom);
         fe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         v[m_act]  = 1'b1;
         fe[m_act] = fe_last && (b == nb - 1);
         step(0, md, (b >= nb / 2) ? sel_mid : sel, v, fe);
         if (b == 0 && exp_ch >= 0) check("act_ch", 32'(o_out_ch), 32'(exp_ch));
      end
   endtask

   task automatic idle_pulses(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 3'd2, 4'($urandom), 4'($urandom));
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      reset_n = 1'b1;
      idle_pulses(5);
      frame(0, 3'd2, 3'd2, 10, 1, 2);
      check("pix_10", 32'(o_pix_count), 10);
      check("pixv_10", 32'(o_pix_count_valid), 1);
      frame(0, 3'd2, 3'd1, 6, 1, 2);
      check("ch_hold", 32'(o_out_ch), 2);
      frame(0, 3'd1, 3'd1, 4, 1, 1);
      for (int i = 0; i < 5; i++) frame(1, 3'd0, 3'd0, 3, 1, seq[i]);
      frame(0, 3'd5, 3'd5, 3, 1, 0);
      check("err_set", 32'(o_sel_err), 1);
      frame(0, 3'd3, 3'd3, 3, 1, 3);
      check("err_clr", 32'(o_sel_err), 0);
      frame(0, 3'd6, 3'd6, 2, 1, 0);
      check("err_set2", 32'(o_sel_err), 1);
      frame(1, 3'd6, 3'd6, 2, 1, 0);
      check("err_auto_clr", 32'(o_sel_err), 0);
      frame(0, 3'd1, 3'd1, 20, 1, 1);
      check("pix_sat", 32'(o_pix_count), 15);
      frame(0, 3'd0, 3'd0, 3, 0, 0);
      step(1, 0, 3'd2, 4'b0001, 4'b0001);
      check("pix_sf_fe", 32'(o_pix_count), 4);
      check("pixv_sf_fe", 32'(o_pix_count_valid), 1);
      step(0, 0, 3'd2, 4'b0100, 4'b0000);
      step(0, 0, 3'd2, 4'b0100, 4'b0000);
      step(0, 0, 3'd2, 4'b0100, 4'b0100);
      check("pix_after_sf", 32'(o_pix_count), 3);
      frame(0, 3'd3, 3'd3, 5, 0, 3);
      i_start_frame = 0; i_in_valid = '0; i_in_frame_end = '0;
      reset_n = 1'b0;
      #2;
      model_reset();
      check_reset_vals();
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle_pulses(6);
      check_reset_vals();
      check("queue_empty", 32'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
